// File: rtl/fcta_pkg.sv
// Shared definitions for the FCTA command dispatcher.
// Field layout of the packed command word, DataMover BTT range, FSM states.
package fcta_pkg;

    localparam int CFG_LSB = 0;
    localparam int BTT_MSB = 22;
    localparam int BTT_LSB = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

    function automatic int mm2s_lsb(input int cfg_bw);
        return cfg_bw;
    endfunction

    function automatic int s2mm_lsb(input int cfg_bw, input int cmd_w);
        return cfg_bw + cmd_w;
    endfunction

endpackage

// File: rtl/fcta_cmd_slot.sv
// One output channel: pending flag plus held data word.
// Loads on accept, clears on its own valid/ready handshake.
module fcta_cmd_slot #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         load_pend,
    input  logic [W-1:0] load_data,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         pend_hold
);

    logic         pend;
    logic [W-1:0] data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= 1'b0;
            data <= '0;
        end else if (load) begin
            pend <= load_pend;
            data <= load_data;
        end else if (pend && tready) begin
            pend <= 1'b0;
        end
    end

    assign tvalid    = pend;
    assign tdata     = data;
    // still pending after this cycle's handshake
    assign pend_hold = pend & ~tready;

endmodule

// File: rtl/fcta_cmd_dispatch.sv
// Forks the packed FCTA command into cfg/MM2S/S2MM streams and
// bounds the number of S2MM transfers in flight.
module fcta_cmd_dispatch
    import fcta_pkg::*;
#(
    parameter int CFG_BW           = 96,
    parameter int AXI_DM_CMD_WIDTH = 72,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int CNT_BW           = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_axis_cmd_tvalid,
    input  logic [CFG_BW+2*AXI_DM_CMD_WIDTH-1:0] s_axis_cmd_tdata,
    output logic                        s_axis_cmd_tready,
    output logic                        m_axis_cfg_tvalid,
    output logic [CFG_BW-1:0]           m_axis_cfg_tdata,
    input  logic                        m_axis_cfg_tready,
    output logic                        m_axis_mm2s_cmd_tvalid,
    output logic [AXI_DM_CMD_WIDTH-1:0] m_axis_mm2s_cmd_tdata,
    input  logic                        m_axis_mm2s_cmd_tready,
    output logic                        m_axis_s2mm_cmd_tvalid,
    output logic [AXI_DM_CMD_WIDTH-1:0] m_axis_s2mm_cmd_tdata,
    input  logic                        m_axis_s2mm_cmd_tready,
    input  logic                        s2mm_done,
    output logic [7:0]                  outstanding,
    output logic [CNT_BW-1:0]           cmd_count,
    output logic                        err_underflow,
    output logic                        busy
);

    localparam int W        = AXI_DM_CMD_WIDTH;
    localparam int MM2S_LSB = mm2s_lsb(CFG_BW);
    localparam int S2MM_LSB = s2mm_lsb(CFG_BW, W);
    localparam logic [7:0] MAX_O = 8'(MAX_OUTSTANDING);

    state_t state, state_nx;

    logic [CFG_BW-1:0] cfg_word;
    logic [W-1:0]      mm2s_word;
    logic [W-1:0]      s2mm_word;
    logic              mm2s_nz;
    logic              s2mm_nz;
    logic              credit_ok;
    logic              accept;
    logic              inc;
    logic              cfg_hold;
    logic              mm2s_hold;
    logic              s2mm_hold;

    assign cfg_word  = s_axis_cmd_tdata[CFG_LSB +: CFG_BW];
    assign mm2s_word = s_axis_cmd_tdata[MM2S_LSB +: W];
    assign s2mm_word = s_axis_cmd_tdata[S2MM_LSB +: W];
    assign mm2s_nz   = |mm2s_word[BTT_MSB:BTT_LSB];
    assign s2mm_nz   = |s2mm_word[BTT_MSB:BTT_LSB];

    // credit judged on the registered count only
    assign credit_ok         = (outstanding < MAX_O);
    assign s_axis_cmd_tready = (state == IDLE) && credit_ok;
    assign busy              = (state == DISPATCH);
    assign inc               = accept && s2mm_nz;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (s_axis_cmd_tvalid && credit_ok) begin
                    accept   = 1'b1;
                    state_nx = DISPATCH;
                end
            end
            DISPATCH: begin
                if (!(cfg_hold || mm2s_hold || s2mm_hold)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
            cmd_count     <= '0;
        end else begin
            if (accept) begin
                cmd_count <= cmd_count + CNT_BW'(1);
            end
            unique case ({inc, s2mm_done})
                2'b10: outstanding <= outstanding + 8'd1;
                2'b01: begin
                    if (outstanding == 8'd0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        outstanding <= outstanding - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    fcta_cmd_slot #(.W(CFG_BW)) u_cfg (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept),
        .load_pend (1'b1),
        .load_data (cfg_word),
        .tready    (m_axis_cfg_tready),
        .tvalid    (m_axis_cfg_tvalid),
        .tdata     (m_axis_cfg_tdata),
        .pend_hold (cfg_hold)
    );

    fcta_cmd_slot #(.W(W)) u_mm2s (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept),
        .load_pend (mm2s_nz),
        .load_data (mm2s_word),
        .tready    (m_axis_mm2s_cmd_tready),
        .tvalid    (m_axis_mm2s_cmd_tvalid),
        .tdata     (m_axis_mm2s_cmd_tdata),
        .pend_hold (mm2s_hold)
    );

    fcta_cmd_slot #(.W(W)) u_s2mm (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept),
        .load_pend (s2mm_nz),
        .load_data (s2mm_word),
        .tready    (m_axis_s2mm_cmd_tready),
        .tvalid    (m_axis_s2mm_cmd_tvalid),
        .tdata     (m_axis_s2mm_cmd_tdata),
        .pend_hold (s2mm_hold)
    );

endmodule

// File: tb/tb_fcta_cmd_dispatch.sv
// Directed self-checking bench for fcta_cmd_dispatch.
// Each scenario task drives stimulus and checks inline.
module tb_fcta_cmd_dispatch;

    localparam int CFG_BW = 96;
    localparam int W      = 72;
    localparam int MAXO   = 4;
    localparam int CNT_BW = 16;
    localparam int TW     = CFG_BW + 2 * W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              s_tvalid = 1'b0;
    logic [TW-1:0]     s_tdata = '0;
    logic              s_tready;
    logic              cfg_tvalid;
    logic [CFG_BW-1:0] cfg_tdata;
    logic              cfg_tready = 1'b1;
    logic              mm2s_tvalid;
    logic [W-1:0]      mm2s_tdata;
    logic              mm2s_tready = 1'b1;
    logic              s2mm_tvalid;
    logic [W-1:0]      s2mm_tdata;
    logic              s2mm_tready = 1'b1;
    logic              s2mm_done = 1'b0;
    logic [7:0]        outstanding;
    logic [CNT_BW-1:0] cmd_count;
    logic              err_underflow;
    logic              busy;
    logic [2:0]        vld;

    int n_cmp = 0;
    int n_err = 0;

    assign vld = {cfg_tvalid, mm2s_tvalid, s2mm_tvalid};

    always #5 clk = ~clk;

    fcta_cmd_dispatch #(
        .CFG_BW           (CFG_BW),
        .AXI_DM_CMD_WIDTH (W),
        .MAX_OUTSTANDING  (MAXO),
        .CNT_BW           (CNT_BW)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .s_axis_cmd_tvalid      (s_tvalid),
        .s_axis_cmd_tdata       (s_tdata),
        .s_axis_cmd_tready      (s_tready),
        .m_axis_cfg_tvalid      (cfg_tvalid),
        .m_axis_cfg_tdata       (cfg_tdata),
        .m_axis_cfg_tready      (cfg_tready),
        .m_axis_mm2s_cmd_tvalid (mm2s_tvalid),
        .m_axis_mm2s_cmd_tdata  (mm2s_tdata),
        .m_axis_mm2s_cmd_tready (mm2s_tready),
        .m_axis_s2mm_cmd_tvalid (s2mm_tvalid),
        .m_axis_s2mm_cmd_tdata  (s2mm_tdata),
        .m_axis_s2mm_cmd_tready (s2mm_tready),
        .s2mm_done              (s2mm_done),
        .outstanding            (outstanding),
        .cmd_count              (cmd_count),
        .err_underflow          (err_underflow),
        .busy                   (busy)
    );

    localparam logic [CFG_BW-1:0] CFG1 = 96'h1;
    localparam logic [W-1:0] MM2S1 = {49'h0, 23'h100};
    localparam logic [W-1:0] S2MM1 = {49'h0, 23'h200};
    localparam logic [CFG_BW-1:0] CFG2 = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    localparam logic [W-1:0] MM2S2 = {49'h1_2345_6789_ABCD, 23'h40};
    localparam logic [W-1:0] S2MM2 = {49'h0_FEDC_BA98_7654, 23'h7F_FFFF};
    localparam logic [CFG_BW-1:0] CFG3 = 96'hA5A5_0000_5A5A;
    localparam logic [W-1:0] MM2S0 = {49'h1_0000_0000_0001, 23'h0};
    localparam logic [W-1:0] S2MM0 = {49'h0_8000_0000_0000, 23'h0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TW-1:0] w);
        s_tvalid = 1'b1;
        s_tdata  = w;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        n_cmp++;
        if ({vld, busy, s_tready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 00001", {vld, busy, s_tready});
        end
        n_cmp++;
        if ({cfg_tdata, mm2s_tdata, s2mm_tdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got nonzero tdata");
        end
        n_cmp++;
        if ({outstanding, cmd_count, err_underflow} !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got out=%0d cnt=%0d err=%b want 0/0/0",
                     outstanding, cmd_count, err_underflow);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single();
        send({S2MM1, MM2S1, CFG1});
        n_cmp++;
        if (vld !== 3'b111) begin
            n_err++;
            $display("FAIL single_vld: got %b want 111", vld);
        end
        n_cmp++;
        if ({cfg_tdata, mm2s_tdata, s2mm_tdata} !== {CFG1, MM2S1, S2MM1}) begin
            n_err++;
            $display("FAIL single_data: got %h want %h",
                     {cfg_tdata, mm2s_tdata, s2mm_tdata}, {CFG1, MM2S1, S2MM1});
        end
        n_cmp++;
        if ({busy, s_tready} !== 2'b10) begin
            n_err++;
            $display("FAIL single_busy: got %b want 10", {busy, s_tready});
        end
        n_cmp++;
        if (outstanding !== 8'd1 || cmd_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_cnt: got out=%0d cnt=%0d want 1/1",
                     outstanding, cmd_count);
        end
        step();
        n_cmp++;
        if ({busy, s_tready, vld} !== 5'b01000) begin
            n_err++;
            $display("FAIL single_idle: got %b want 01000", {busy, s_tready, vld});
        end
    endtask

    task automatic test_staggered();
        logic [2:0] exp_v;
        cfg_tready  = 1'b0;
        mm2s_tready = 1'b0;
        s2mm_tready = 1'b0;
        send({S2MM2, MM2S2, CFG2});
        n_cmp++;
        if (vld !== 3'b111 || outstanding !== 8'd2) begin
            n_err++;
            $display("FAIL stag_start: got vld=%b out=%0d want 111/2",
                     vld, outstanding);
        end
        for (int k = 1; k <= 5; k++) begin
            cfg_tready  = (k == 1);
            s2mm_tready = (k == 3);
            mm2s_tready = (k == 5);
            step();
            exp_v = {1'b0, k < 5, k < 3};
            n_cmp++;
            if (vld !== exp_v) begin
                n_err++;
                $display("FAIL stag_vld_%0d: got %b want %b", k, vld, exp_v);
            end
            n_cmp++;
            if ({cfg_tdata, mm2s_tdata, s2mm_tdata} !== {CFG2, MM2S2, S2MM2}) begin
                n_err++;
                $display("FAIL stag_data_%0d: got %h want %h", k,
                         {cfg_tdata, mm2s_tdata, s2mm_tdata}, {CFG2, MM2S2, S2MM2});
            end
            n_cmp++;
            if (s_tready !== (k == 5)) begin
                n_err++;
                $display("FAIL stag_rdy_%0d: got %b want %b", k, s_tready, k == 5);
            end
        end
        cfg_tready  = 1'b1;
        mm2s_tready = 1'b1;
        s2mm_tready = 1'b1;
    endtask

    task automatic test_zero_btt();
        send({S2MM0, MM2S0, CFG3});
        n_cmp++;
        if (vld !== 3'b100 || cfg_tdata !== CFG3) begin
            n_err++;
            $display("FAIL zero_vld: got vld=%b cfg=%h want 100/%h",
                     vld, cfg_tdata, CFG3);
        end
        n_cmp++;
        if (outstanding !== 8'd2 || cmd_count !== 16'd3) begin
            n_err++;
            $display("FAIL zero_cnt: got out=%0d cnt=%0d want 2/3",
                     outstanding, cmd_count);
        end
        step();
        n_cmp++;
        if ({busy, vld} !== 4'b0000) begin
            n_err++;
            $display("FAIL zero_idle: got %b want 0000", {busy, vld});
        end
    endtask

    task automatic test_coincide();
        s_tvalid  = 1'b1;
        s_tdata   = {S2MM1, MM2S1, CFG1};
        s2mm_done = 1'b1;
        step();
        s_tvalid  = 1'b0;
        s2mm_done = 1'b0;
        n_cmp++;
        if (outstanding !== 8'd2 || cmd_count !== 16'd4 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL coincide: got out=%0d cnt=%0d busy=%b want 2/4/1",
                     outstanding, cmd_count, busy);
        end
        step();
    endtask

    task automatic test_underflow();
        s2mm_done = 1'b1;
        step();
        step();
        s2mm_done = 1'b0;
        n_cmp++;
        if (outstanding !== 8'd0 || err_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got out=%0d err=%b want 0/0",
                     outstanding, err_underflow);
        end
        s2mm_done = 1'b1;
        step();
        s2mm_done = 1'b0;
        n_cmp++;
        if (outstanding !== 8'd0 || err_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow: got out=%0d err=%b want 0/1",
                     outstanding, err_underflow);
        end
        step();
        n_cmp++;
        if (err_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_sticky: got %b want 1", err_underflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            send({S2MM1, MM2S2, CFG1});
            step();
            n_cmp++;
            if (s_tready !== (i < 3)) begin
                n_err++;
                $display("FAIL b2b_rdy_%0d: got %b want %b", i, s_tready, i < 3);
            end
        end
        n_cmp++;
        if (outstanding !== 8'd4 || cmd_count !== 16'd8) begin
            n_err++;
            $display("FAIL b2b_cnt: got out=%0d cnt=%0d want 4/8",
                     outstanding, cmd_count);
        end
        s_tvalid = 1'b1;
        s_tdata  = {S2MM2, MM2S2, CFG2};
        step();
        step();
        n_cmp++;
        if ({busy, s_tready} !== 2'b00 || cmd_count !== 16'd8) begin
            n_err++;
            $display("FAIL b2b_stall: got busy/rdy=%b cnt=%0d want 00/8",
                     {busy, s_tready}, cmd_count);
        end
        s2mm_done = 1'b1;
        step();
        s2mm_done = 1'b0;
        n_cmp++;
        if (s_tready !== 1'b1 || outstanding !== 8'd3) begin
            n_err++;
            $display("FAIL b2b_credit: got rdy=%b out=%0d want 1/3",
                     s_tready, outstanding);
        end
        step();
        s_tvalid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || outstanding !== 8'd4 || cmd_count !== 16'd9) begin
            n_err++;
            $display("FAIL b2b_fifth: got busy=%b out=%0d cnt=%0d want 1/4/9",
                     busy, outstanding, cmd_count);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || outstanding !== 8'd4 || s_tready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got busy=%b out=%0d rdy=%b want 0/4/0",
                     busy, outstanding, s_tready);
        end
    endtask

    task automatic test_reset_mid();
        s2mm_done = 1'b1;
        step();
        s2mm_done   = 1'b0;
        cfg_tready  = 1'b0;
        mm2s_tready = 1'b0;
        s2mm_tready = 1'b0;
        send({S2MM2, MM2S2, CFG2});
        n_cmp++;
        if (busy !== 1'b1 || vld !== 3'b111) begin
            n_err++;
            $display("FAIL rmid_pre: got busy=%b vld=%b want 1/111", busy, vld);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({vld, busy, s_tready} !== 5'b00001) begin
            n_err++;
            $display("FAIL rmid_ctl: got %b want 00001", {vld, busy, s_tready});
        end
        n_cmp++;
        if ({cfg_tdata, mm2s_tdata, s2mm_tdata} !== '0 ||
            {outstanding, cmd_count, err_underflow} !== '0) begin
            n_err++;
            $display("FAIL rmid_regs: got out=%0d cnt=%0d err=%b want 0/0/0",
                     outstanding, cmd_count, err_underflow);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        cfg_tready  = 1'b1;
        mm2s_tready = 1'b1;
        s2mm_tready = 1'b1;
        n_cmp++;
        if ({vld, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_noreplay: got %b want 0000", {vld, busy});
        end
        send({S2MM1, MM2S1, CFG3});
        n_cmp++;
        if (vld !== 3'b111 || outstanding !== 8'd1 || cmd_count !== 16'd1) begin
            n_err++;
            $display("FAIL rmid_new: got vld=%b out=%0d cnt=%0d want 111/1/1",
                     vld, outstanding, cmd_count);
        end
        n_cmp++;
        if ({cfg_tdata, mm2s_tdata, s2mm_tdata} !== {CFG3, MM2S1, S2MM1}) begin
            n_err++;
            $display("FAIL rmid_data: got %h want %h",
                     {cfg_tdata, mm2s_tdata, s2mm_tdata}, {CFG3, MM2S1, S2MM1});
        end
        step();
        n_cmp++;
        if ({busy, vld} !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_idle: got %b want 0000", {busy, vld});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_staggered();
        test_zero_btt();
        test_coincide();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fcta_cmd_dispatch.md
# fcta_cmd_dispatch

Receiving end of the FCTA controller's packed command stream. It accepts one combined word holding the FCTA configuration, the DataMover MM2S command and the DataMover S2MM command. It forks that word into three independent AXI-Stream masters: the FCTA config port and the two DataMover command ports. It also bounds the number of S2MM transfers in flight using completion pulses from the S2MM status path.

## Interface
Parameters:
- CFG_BW, 96: FCTA config word width.
- AXI_DM_CMD_WIDTH, 72: DataMover command width.
- MAX_OUTSTANDING, 4: maximum S2MM commands dispatched and not yet completed (range 1..255).
- CNT_BW, 16: width of the dispatched-command counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- s_axis_cmd_tvalid  in  1  packed command valid.
- s_axis_cmd_tdata  in  CFG_BW+2*AXI_DM_CMD_WIDTH  packed command.
  - [CFG_BW-1:0] = cfg.
  - next AXI_DM_CMD_WIDTH bits = mm2s.
  - top AXI_DM_CMD_WIDTH bits = s2mm.
- s_axis_cmd_tready  out  1  command accepted.
- m_axis_cfg_tvalid / m_axis_cfg_tdata / m_axis_cfg_tready  out / out / in  1 / CFG_BW / 1  FCTA config stream.
- m_axis_mm2s_cmd_tvalid / _tdata / _tready  out / out / in  1 / AXI_DM_CMD_WIDTH / 1  MM2S command stream.
- m_axis_s2mm_cmd_tvalid / _tdata / _tready  out / out / in  1 / AXI_DM_CMD_WIDTH / 1  S2MM command stream.
- s2mm_done  in  1  single-cycle pulse, one per completed S2MM transfer.
- outstanding  out  8  S2MM commands currently in flight.
- cmd_count  out  CNT_BW  commands accepted since reset; wraps.
- err_underflow  out  1  sticky flag: s2mm_done arrived while outstanding==0.
- busy  out  1  high in the DISPATCH state.

## Operation
- Two states: IDLE and DISPATCH.
- IDLE:
  - s_axis_cmd_tready = (outstanding < MAX_OUTSTANDING), using the registered count only.
  - On handshake: latch the word into a holding register, set pend_cfg=1, set pend_mm2s = (mm2s BTT[22:0] != 0), set pend_s2mm = (s2mm BTT[22:0] != 0).
  - Go to DISPATCH, increment cmd_count, and increment outstanding if pend_s2mm is set.
- DISPATCH:
  - Each m_*_tvalid equals its pend flag; the tdata outputs come from the holding register and stay stable while tvalid is high.
  - A flag clears on its own tvalid&tready handshake.
  - Outputs complete in any order, independently; none waits for another.
  - When every flag is clear after this cycle's handshakes, return to IDLE.
- Zero-BTT sub-commands are never emitted. The config word is always emitted.
- Outstanding counter:
  - Increment on an accept with an S2MM command, decrement on s2mm_done.
  - Both in the same cycle: no change.
  - s2mm_done while at 0 and no increment: count stays 0 and err_underflow is set until reset.
- s2mm_done is honoured in any state.

## Timing
- Reset values:
  - state IDLE; all pend flags 0; every m_*_tvalid 0.
  - s_axis_cmd_tready 1, since outstanding=0.
  - all tdata outputs 0; outstanding 0; cmd_count 0; err_underflow 0; busy 0.
- Accept in cycle N: the corresponding tvalids are high from N+1. Registered outputs; no combinational path from s_axis to m_axis.
- Last output handshake in cycle M: IDLE in M+1, with tready high in M+1 if credit allows. Peak throughput is one command per 2 cycles.
- Dispatch stalls in IDLE with tready low when outstanding==MAX_OUTSTANDING. A done pulse in cycle K raises tready in K+1.
- cmd_count wraps from 2^CNT_BW-1 to 0.
- Reset asserted mid-DISPATCH:
  - All tvalids drop asynchronously.
  - The held command is discarded and is not replayed.

## Structure
- Shared package fcta_pkg holds:
  - field offsets for the cfg, mm2s and s2mm slices;
  - the DataMover BTT range (22:0);
  - the state enum {IDLE, DISPATCH}.
- The three output channels are identical. Use one sub-module, fcta_cmd_slot: a pend flag plus data register with a load and handshake-clear, instantiated three times with widths CFG_BW, AXI_DM_CMD_WIDTH, AXI_DM_CMD_WIDTH.
- The top level holds the FSM, the credit counter and cmd_count.

## Test plan
- Single command, cfg=96'h1, mm2s BTT=0x100, s2mm BTT=0x200, all treadys high:
  - all three tvalids high the cycle after accept;
  - back in IDLE 2 cycles after accept;
  - outstanding=1, cmd_count=1.
- Staggered readiness: cfg_tready at +1, mm2s at +5, s2mm at +3 cycles:
  - each tvalid drops right after its own handshake;
  - tdata stays stable throughout;
  - tready returns the cycle after the mm2s handshake.
- mm2s BTT=0 and s2mm BTT=0:
  - only cfg is emitted;
  - outstanding is unchanged.
- MAX_OUTSTANDING=4, five back-to-back commands, no done pulses:
  - the fifth is stalled with tready=0;
  - one s2mm_done raises tready the next cycle;
  - outstanding ends at 4.
- s2mm_done coinciding with an accept at outstanding=2: outstanding stays 2.
- s2mm_done at outstanding=0: err_underflow=1 and outstanding=0.
- rstn pulsed low during DISPATCH: all outputs return to their reset values; after release, a new command is dispatched normally.
